// File: rtl/ped_request_unit_if.sv
// Pedestrian request bus: raw button and walk acknowledge in, request/lamp/status out.
interface ped_request_unit_if;
    logic       btn_raw;
    logic       ped_walk;
    logic       ped_req;
    logic       wait_lamp;
    logic       busy;
    logic [7:0] press_count;

    modport master (
        output btn_raw,
        output ped_walk,
        input  ped_req,
        input  wait_lamp,
        input  busy,
        input  press_count
    );

    modport slave (
        input  btn_raw,
        input  ped_walk,
        output ped_req,
        output wait_lamp,
        output busy,
        output press_count
    );
endinterface

// File: rtl/ped_request_unit.sv
// Push-button conditioner for the traffic light controller: sync, debounce, latch the
// request, re-issue ped_req pulses until walk is served, then hold a post-walk lockout.
module ped_request_unit #(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned RETRY_CYCLES    = 32,
    parameter int unsigned COOLDOWN_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    ped_request_unit_if.slave  bus
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TMAX = (RETRY_CYCLES > COOLDOWN_CYCLES) ? RETRY_CYCLES
                                                                    : COOLDOWN_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PENDING  = 2'd1,
        S_SERVING  = 2'd2,
        S_COOLDOWN = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_s1;
    logic            r_s2;
    logic            r_db;
    logic            r_db_d;
    logic [DB_W-1:0] r_db_cnt;
    logic [TW-1:0]   r_timer;
    logic            r_ped_req;
    logic            r_wait_lamp;
    logic            r_busy;
    logic [7:0]      r_press_count;

    logic            w_press;

    // A press is the rising edge of the debounced level, so a held button fires once.
    assign w_press = r_db & ~r_db_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1          <= 1'b0;
            r_s2          <= 1'b0;
            r_db          <= 1'b0;
            r_db_d        <= 1'b0;
            r_db_cnt      <= '0;
            r_timer       <= '0;
            r_state       <= S_IDLE;
            r_ped_req     <= 1'b0;
            r_wait_lamp   <= 1'b0;
            r_busy        <= 1'b0;
            r_press_count <= '0;
        end else begin
            r_s1   <= bus.btn_raw;
            r_s2   <= r_s1;
            r_db_d <= r_db;

            if (r_s2 == r_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_db     <= r_s2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end

            r_ped_req <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_press && !bus.ped_walk) begin
                        r_state     <= S_PENDING;
                        r_ped_req   <= 1'b1;
                        r_wait_lamp <= 1'b1;
                        r_timer     <= TW'(RETRY_CYCLES - 1);
                        if (r_press_count != 8'hFF) begin
                            r_press_count <= r_press_count + 8'd1;
                        end
                    end
                end
                // Walk acknowledge beats a retry that falls due on the same cycle.
                S_PENDING: begin
                    if (bus.ped_walk) begin
                        r_state     <= S_SERVING;
                        r_wait_lamp <= 1'b0;
                        r_busy      <= 1'b1;
                    end else if (r_timer == '0) begin
                        if (!r_ped_req) begin
                            r_ped_req <= 1'b1;
                            r_timer   <= TW'(RETRY_CYCLES - 1);
                        end
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                S_SERVING: begin
                    if (!bus.ped_walk) begin
                        if (COOLDOWN_CYCLES == 0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_COOLDOWN;
                            r_timer <= TW'(COOLDOWN_CYCLES);
                        end
                    end
                end
                S_COOLDOWN: begin
                    if (r_timer <= TW'(1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_wait_lamp <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ped_req     = r_ped_req;
    assign bus.wait_lamp   = r_wait_lamp;
    assign bus.busy        = r_busy;
    assign bus.press_count = r_press_count;

endmodule

// File: doc/ped_request_unit.md
Name: ped_request_unit

Overview:
- Upstream conditioning stage for traffic_light_controller; takes a raw pedestrian push-button and drives the controller's ped_req input.
- Synchronises and debounces the button, then latches a request until the controller serves it with ped_walk.
- Re-issues single-cycle ped_req pulses while the request is outstanding, and enforces a post-walk lockout.
- Drives the "WAIT" lamp and keeps an accepted-press statistic.

Parameters:
DEBOUNCE_CYCLES, 8, consecutive cycles the synchronised button must differ from the debounced level before that level flips (>=1)
RETRY_CYCLES, 32, cycles between repeated ped_req pulses while a request is pending (>=1)
COOLDOWN_CYCLES, 16, cycles after ped_walk falls during which presses are ignored (0 = no lockout)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
btn_raw  input  1  asynchronous, bouncy push-button level, 1 = pressed
ped_walk  input  1  from traffic_light_controller; 1 = walk phase active (service acknowledge)
ped_req  output  1  registered single-cycle request pulse to traffic_light_controller
wait_lamp  output  1  1 while a request is pending and not yet served
busy  output  1  1 in SERVING or COOLDOWN (presses ignored)
press_count  output  8  count of accepted presses, saturates at 255

Behaviour:
- Reset (synchronous): sync flops=0, debounced level db=0, db_d=0, debounce counter=0, retry/cooldown counters=0, state=IDLE; ped_req=0, wait_lamp=0, busy=0, press_count=0.
- Synchroniser: 2 flops, btn_raw -> s1 -> s2.
- Debounce:
  - Counter increments each cycle s2!=db and clears when s2==db.
  - When the counter reaches DEBOUNCE_CYCLES, db takes the value of s2 and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change db.
- Press event: db==1 && db_d==0, where db_d is db delayed one cycle.
- Latency: if btn_raw is first sampled 1 at edge k and stays stable, db=1 after edge k+1+DEBOUNCE_CYCLES and ped_req is high for exactly one cycle after edge k+2+DEBOUNCE_CYCLES.
- FSM states: IDLE, PENDING, SERVING, COOLDOWN.
  - IDLE:
    - Press event with ped_walk==0 -> PENDING; ped_req=1 next cycle; retry counter loads RETRY_CYCLES-1; press_count+1 (saturating).
    - Press event with ped_walk==1 -> ignored, stay IDLE, no count.
    - ped_walk alone causes no transition.
  - PENDING:
    - wait_lamp=1.
    - ped_walk==1 -> SERVING. This has priority: no ped_req that cycle even if a retry is due.
    - Otherwise the retry counter decrements; at 0, emit a one-cycle ped_req and reload RETRY_CYCLES-1.
    - Further press events are absorbed (no count, no extra pulse).
  - SERVING:
    - busy=1.
    - ped_walk==0 -> COOLDOWN with counter loaded COOLDOWN_CYCLES; if COOLDOWN_CYCLES==0, go to IDLE instead.
    - Presses are ignored.
  - COOLDOWN:
    - busy=1.
    - Counter decrements each cycle; on reaching 0 -> IDLE.
    - Presses are ignored. A press still held at exit does not re-trigger, because the edge has already passed.
- ped_req is never high on two consecutive cycles and is never high outside PENDING entry/retry.
- press_count holds at 255 once it reaches 255.
- Reset mid-operation: any state -> IDLE in the next cycle, outputs cleared. A button still held after reset is seen as a new press after the full debounce latency, because db restarts at 0.
- Simultaneous press event and reset: reset wins.

Test Plan:
- DEBOUNCE=4: clean press, btn_raw 0->1 sampled at edge k -> exactly one ped_req pulse after edge k+6; wait_lamp=1; press_count=1.
- DEBOUNCE=4: bounce of 1-0-1-0 with 1-cycle and 3-cycle high pulses -> db stays 0; no ped_req; press_count=0.
- RETRY=16: hold PENDING with ped_walk=0 for 40 cycles -> 3 ped_req pulses spaced 16 cycles apart; raise ped_walk -> SERVING, wait_lamp=0, busy=1.
- COOLDOWN=8: ped_walk falls; press during cooldown -> ignored, press_count unchanged. A clean press 10 cycles after ped_walk falls -> accepted, ped_req pulses.
- Retry due on the same cycle ped_walk rises -> no ped_req; state=SERVING.
- Reset asserted in PENDING, then 300 accepted presses -> state=IDLE and outputs 0 after one edge; press_count saturates at 255.
